// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 device-to-host receiver with input filtering, frame checking and a show-ahead FIFO.
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ps2_clk_i,
    input  logic                          ps2_dat_i,
    input  logic                          en_i,
    input  logic                          rd_i,
    input  logic                          clr_i,
    output logic [7:0]                    dat_o,
    output logic                          empty_o,
    output logic                          full_o,
    output logic [$clog2(FIFO_DEPTH):0]   cnt_o,
    output logic                          par_err_o,
    output logic                          frm_err_o,
    output logic                          ovf_o,
    output logic                          irq_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILT_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]         c_sync, d_sync;
    logic [1:0]         s_line, f_line;
    logic [1:0][FW-1:0] f_cnt;
    logic               f_clk, f_dat, f_clk_q, fall;
    state_t             state;
    logic [2:0]         bit_cnt;
    logic [7:0]         shreg;
    logic               par_bit;
    logic [TW-1:0]      tcnt;
    logic               stop_evt, par_ok, push, timeout, pop, wr;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [AW:0]        wp, rp;

    assign s_line = {d_sync[1], c_sync[1]};
    assign f_clk  = f_line[0];
    assign f_dat  = f_line[1];
    assign fall   = f_clk_q & ~f_clk;

    // index 0 is the clock line, index 1 the data line; both idle high
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            c_sync  <= '1;
            d_sync  <= '1;
            f_line  <= '1;
            f_clk_q <= 1'b1;
            f_cnt   <= '0;
        end else begin
            c_sync  <= {c_sync[0], ps2_clk_i};
            d_sync  <= {d_sync[0], ps2_dat_i};
            f_clk_q <= f_line[0];
            for (int i = 0; i < 2; i++)
                if (s_line[i] == f_line[i])
                    f_cnt[i] <= '0;
                else if (f_cnt[i] == FW'(FILT_LEN - 1)) begin
                    f_line[i] <= s_line[i];
                    f_cnt[i]  <= '0;
                end else
                    f_cnt[i] <= f_cnt[i] + 1'b1;
        end

    assign stop_evt = en_i & fall & (state == STOP);
    assign par_ok   = ^{shreg, par_bit};
    assign push     = stop_evt & f_dat & par_ok;
    assign timeout  = en_i & (state != IDLE) & ~fall & (tcnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tcnt    <= '0;
        end else if (!en_i || timeout) begin
            state <= IDLE;
            tcnt  <= '0;
        end else begin
            tcnt <= (fall || state == IDLE) ? '0 : tcnt + 1'b1;
            if (fall)
                case (state)
                    IDLE: if (!f_dat) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                    DATA: begin
                        shreg   <= {f_dat, shreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    PARITY: begin
                        par_bit <= f_dat;
                        state   <= STOP;
                    end
                    default: state <= IDLE;
                endcase
        end

    assign cnt_o   = wp - rp;
    assign empty_o = cnt_o == '0;
    assign full_o  = cnt_o == (AW + 1)'(FIFO_DEPTH);
    assign irq_o   = ~empty_o;
    assign pop     = rd_i & ~empty_o;
    assign wr      = push & (~full_o | pop);
    assign dat_o   = empty_o ? 8'h00 : mem[rp[AW-1:0]];

    always_ff @(posedge clk_i)
        if (wr) mem[wp[AW-1:0]] <= shreg;

    // a flag being set outranks a clear in the same cycle
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            wp        <= '0;
            rp        <= '0;
            par_err_o <= 1'b0;
            frm_err_o <= 1'b0;
            ovf_o     <= 1'b0;
        end else begin
            wp        <= wp + (AW + 1)'(wr);
            rp        <= rp + (AW + 1)'(pop);
            par_err_o <= (stop_evt & ~par_ok) | (par_err_o & ~clr_i);
            frm_err_o <= (stop_evt & ~f_dat) | timeout | (frm_err_o & ~clr_i);
            ovf_o     <= (push & full_o & ~pop) | (ovf_o & ~clr_i);
        end
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed frames at 12.5 kHz against a 1 MHz system clock.
`timescale 1ns/1ps
module tb_ps2_kbd_rx;
    logic       clk = 0, rst = 1, ps2_clk = 1, ps2_dat = 1, en = 0, rd = 0, clr = 0;
    logic [7:0] dat;
    logic       empty, full, par_err, frm_err, ovf, irq;
    logic [3:0] cnt;
    int         n_chk = 0, n_fail = 0;

    ps2_kbd_rx dut (
        .clk_i(clk), .rst_i(rst), .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
        .en_i(en), .rd_i(rd), .clr_i(clr), .dat_o(dat), .empty_o(empty),
        .full_o(full), .cnt_o(cnt), .par_err_o(par_err), .frm_err_o(frm_err),
        .ovf_o(ovf), .irq_o(irq)
    );

    always #500 clk = ~clk;

    initial begin
        #150_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // strobe: 0 none, 1 pulse rd, 2 pulse clr, aligned with the cycle the stop bit is acted on
    task automatic send_bits(input logic [10:0] bits, input int nb, input int glitch_bit,
                             input int strobe, input bit chk_lat);
        for (int i = 0; i < nb; i++) begin
            ps2_dat = bits[i];
            wait_cyc(20);
            ps2_clk = 0;
            if (i == 10) begin
                wait_cyc(6);
                if (chk_lat) check("lat_pre", empty, 1);
                rd  = (strobe == 1);
                clr = (strobe == 2);
                wait_cyc(1);
                rd  = 0;
                clr = 0;
                if (chk_lat) check("lat_push", empty, 0);
                wait_cyc(33);
            end else
                wait_cyc(40);
            ps2_clk = 1;
            if (glitch_bit == i) begin
                wait_cyc(10);
                ps2_clk = 0;
                wait_cyc(2);
                ps2_clk = 1;
                wait_cyc(8);
            end else
                wait_cyc(20);
        end
        ps2_dat = 1;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par = 0, input bit stop_v = 1,
                              input int glitch_bit = -1, input int strobe = 0, input bit chk_lat = 0);
        send_bits({stop_v, (~^d) ^ bad_par, d, 1'b0}, 11, glitch_bit, strobe, chk_lat);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] exp);
        check(tag, dat, exp);
        rd = 1;
        wait_cyc(1);
        rd = 0;
    endtask

    task automatic clear_flags();
        clr = 1;
        wait_cyc(1);
        clr = 0;
    endtask

    initial begin
        wait_cyc(3);
        check("rst_dat", dat, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_cnt", cnt, 0);
        check("rst_irq", irq, 0);
        check("rst_flags", {par_err, frm_err, ovf}, 0);
        rst = 0;
        wait_cyc(2);

        send_frame(8'h41);
        check("dis_empty", empty, 1);
        en = 1;
        wait_cyc(2);

        send_frame(8'h41, 0, 1, -1, 0, 1);
        check("good_cnt", cnt, 1);
        check("good_dat", dat, 8'h41);
        check("good_irq", irq, 1);
        pop_chk("good_pop", 8'h41);
        check("good_empty", empty, 1);
        check("good_dat0", dat, 0);

        send_frame(8'h41, 1);
        check("par_flag", par_err, 1);
        check("par_empty", empty, 1);
        check("par_nofrm", frm_err, 0);
        send_frame(8'h42, 0, 0);
        check("stop_flag", frm_err, 1);
        check("stop_empty", empty, 1);
        clear_flags();
        check("clr_flags", {par_err, frm_err}, 0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 9; k++) begin
                send_frame(8'(8'h41 + k));
                if (k == 7) check("fill8_full_noovf", {full, ovf}, 2'b10);
            end
            check("ovf_full", full, 1);
            check("ovf_cnt", cnt, 8);
            check("ovf_flag", ovf, 1);
            for (int k = 0; k < 8; k++) pop_chk("ovf_pop", 8'(8'h41 + k));
            check("ovf_drained", empty, 1);
            clear_flags();
        end

        send_bits(11'h02A, 6, -1, 0, 0);
        wait_cyc(19000);
        check("to_early", frm_err, 0);
        wait_cyc(1500);
        check("to_flag", frm_err, 1);
        check("to_empty", empty, 1);
        clear_flags();
        send_frame(8'h5A);
        check("to_next_dat", dat, 8'h5A);
        check("to_next_flags", {par_err, frm_err}, 0);
        pop_chk("to_pop", 8'h5A);

        send_frame(8'h33, 0, 1, 3);
        check("gl_cnt", cnt, 1);
        check("gl_dat", dat, 8'h33);
        check("gl_flags", {par_err, frm_err}, 0);
        pop_chk("gl_pop", 8'h33);

        for (int k = 0; k < 8; k++) send_frame(8'(8'h41 + k));
        send_frame(8'h49, 0, 1, -1, 1);
        check("sim_cnt", cnt, 8);
        check("sim_full", full, 1);
        check("sim_ovf", ovf, 0);
        for (int k = 0; k < 8; k++) pop_chk("sim_pop", 8'(8'h42 + k));
        check("sim_empty", empty, 1);

        send_frame(8'h41, 1, 1, -1, 2);
        check("clr_race_par", par_err, 1);
        check("clr_race_empty", empty, 1);

        send_frame(8'h41);
        check("mid_cnt", cnt, 1);
        send_bits(11'h02A, 4, -1, 0, 0);
        rst = 1;
        wait_cyc(2);
        check("mid_dat", dat, 0);
        check("mid_empty", empty, 1);
        check("mid_cnt0", cnt, 0);
        check("mid_irq", irq, 0);
        check("mid_flags", {par_err, frm_err, ovf, full}, 0);
        rst = 0;
        wait_cyc(2);
        send_frame(8'h5A);
        check("post_rst_cnt", cnt, 1);
        check("post_rst_dat", dat, 8'h5A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
